rv32b_exec: RTL and testbench

RV32B_EXEC -- requirements
Module: rv32b_exec

---
 rtl/rv32b_pkg.sv | 37 +++
 rtl/rv32b_exec.sv | 181 ++++++++++++++++++
 tb/tb_rv32b_exec.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rv32b_pkg.sv
// Shared types for the RV32B bit-manipulation execute unit.
// The decoder hands the execute unit a {claim, operation} word.
package rv32b_pkg;

    typedef enum logic [4:0] {
        OP_SH1ADD,
        OP_SH2ADD,
        OP_SH3ADD,
        OP_ANDN,
        OP_ORN,
        OP_XNOR,
        OP_ROL,
        OP_ROR,
        OP_BCLR,
        OP_BSET,
        OP_BINV,
        OP_BEXT,
        OP_MIN,
        OP_MAX,
        OP_MINU,
        OP_MAXU,
        OP_SEXTB,
        OP_SEXTH,
        OP_ZEXTH,
        OP_REV8,
        OP_ORC,
        OP_CLZ,
        OP_CTZ,
        OP_CPOP
    } rv32b_op_e;

    typedef struct packed {
        logic      claim;
        rv32b_op_e op;
    } rv32b_decode_t;

endpackage

// File: rtl/rv32b_exec.sv
// RV32B execute unit: single-cycle ALU ops plus an iterative
// CLZ/CTZ/CPOP engine scanning STEP_BITS bits per clock.
module rv32b_exec
    import rv32b_pkg::*;
#(
    parameter int STEP_BITS = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          start,
    input  rv32b_decode_t rv32b_control,
    input  logic [31:0]   rs1_data,
    input  logic [31:0]   rs2_data,
    input  logic          flush,
    output logic          busy,
    output logic          done,
    output logic [31:0]   result
);

    localparam int NSTEP = 32 / STEP_BITS;
    localparam logic [5:0] LAST = 6'(NSTEP - 1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] opnd_q, opnd_d;
    logic        cpop_q, cpop_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  acc_q, acc_d;
    logic        found_q, found_d;
    logic [31:0] result_q, result_d;

    logic [31:0] alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [63:0] dbl;
    logic [63:0] dbl_l;
    logic [63:0] dbl_r;
    logic [31:0] rev;
    logic        is_cnt;
    logic        accept;

    logic [STEP_BITS-1:0] slice;
    logic [5:0]  lz;
    logic [5:0]  pc;
    logic        hit;
    logic [5:0]  acc_nxt;

    assign a     = rs1_data;
    assign b     = rs2_data;
    assign sh    = rs2_data[4:0];
    assign dbl   = {a, a};
    assign dbl_l = dbl << sh;
    assign dbl_r = dbl >> sh;

    always_comb begin
        alu = 32'h0;
        unique case (rv32b_control.op)
            OP_SH1ADD: alu = (a << 1) + b;
            OP_SH2ADD: alu = (a << 2) + b;
            OP_SH3ADD: alu = (a << 3) + b;
            OP_ANDN:   alu = a & ~b;
            OP_ORN:    alu = a | ~b;
            OP_XNOR:   alu = ~(a ^ b);
            OP_ROL:    alu = dbl_l[63:32];
            OP_ROR:    alu = dbl_r[31:0];
            OP_BCLR:   alu = a & ~(32'h1 << sh);
            OP_BSET:   alu = a | (32'h1 << sh);
            OP_BINV:   alu = a ^ (32'h1 << sh);
            OP_BEXT:   alu = {31'h0, a[sh]};
            OP_MIN:    alu = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:    alu = ($signed(a) < $signed(b)) ? b : a;
            OP_MINU:   alu = (a < b) ? a : b;
            OP_MAXU:   alu = (a < b) ? b : a;
            OP_SEXTB:  alu = {{24{a[7]}}, a[7:0]};
            OP_SEXTH:  alu = {{16{a[15]}}, a[15:0]};
            OP_ZEXTH:  alu = {16'h0, a[15:0]};
            OP_REV8:   alu = {a[7:0], a[15:8], a[23:16], a[31:24]};
            OP_ORC: begin
                for (int i = 0; i < 4; i++)
                    alu[i*8 +: 8] = (a[i*8 +: 8] != 8'h0) ? 8'hFF : 8'h00;
            end
            default:   alu = 32'h0;
        endcase
    end

    // CTZ is run as CLZ of the bit-reversed operand
    always_comb begin
        rev = 32'h0;
        for (int i = 0; i < 32; i++)
            rev[i] = a[31-i];
    end

    always_comb begin
        slice = opnd_q[31 -: STEP_BITS];
        lz    = 6'd0;
        pc    = 6'd0;
        hit   = found_q;
        for (int i = STEP_BITS - 1; i >= 0; i--) begin
            pc = pc + 6'(slice[i]);
            if (!hit) begin
                if (slice[i]) hit = 1'b1;
                else          lz  = lz + 6'd1;
            end
        end
        acc_nxt = acc_q + (cpop_q ? pc : lz);
    end

    assign is_cnt = rv32b_control.op inside {OP_CLZ, OP_CTZ, OP_CPOP};
    assign accept = (state_q == IDLE) && start &&
                    rv32b_control.claim && !flush;

    always_comb begin
        state_d  = state_q;
        opnd_d   = opnd_q;
        cpop_d   = cpop_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        found_d  = found_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_cnt) begin
                        opnd_d  = (rv32b_control.op == OP_CTZ) ? rev : a;
                        cpop_d  = (rv32b_control.op == OP_CPOP);
                        cnt_d   = 6'd0;
                        acc_d   = 6'd0;
                        found_d = 1'b0;
                        state_d = COUNT;
                    end else begin
                        result_d = alu;
                        state_d  = DONE;
                    end
                end
            end
            COUNT: begin
                opnd_d  = opnd_q << STEP_BITS;
                cnt_d   = cnt_q + 6'd1;
                acc_d   = acc_nxt;
                found_d = hit;
                if (cnt_q == LAST) begin
                    result_d = {26'h0, acc_nxt};
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            opnd_q   <= 32'h0;
            cpop_q   <= 1'b0;
            cnt_q    <= 6'd0;
            acc_q    <= 6'd0;
            found_q  <= 1'b0;
            result_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            opnd_q   <= opnd_d;
            cpop_q   <= cpop_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            found_q  <= found_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_rv32b_exec.sv
// Directed bench for rv32b_exec: ALU vectors, count latency,
// flush, claim gating and asynchronous reset.
module tb_rv32b_exec;
    import rv32b_pkg::*;

    logic          CLK;
    logic          nRST;
    logic          start;
    rv32b_decode_t rv32b_control;
    logic [31:0]   rs1_data;
    logic [31:0]   rs2_data;
    logic          flush;
    logic          busy;
    logic          done;
    logic [31:0]   result;

    int n_cmp;
    int n_bad;

    rv32b_exec #(.STEP_BITS(4)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .start         (start),
        .rv32b_control (rv32b_control),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .flush         (flush),
        .busy          (busy),
        .done          (done),
        .result        (result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input rv32b_op_e op,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int lat);
        int n;
        @(negedge CLK);
        rv32b_control = '{claim: 1'b1, op: op};
        rs1_data = x;
        rs2_data = y;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk({tag, " res"}, result, exp);
        chk({tag, " lat"}, 32'(n), 32'(lat));
        @(posedge CLK);
        #1;
        chk({tag, " idle"}, {30'h0, busy, done}, 32'h0);
    endtask

    task automatic watch_no_done(input string tag, input int cyc);
        int seen;
        seen = 0;
        for (int i = 0; i < cyc; i++) begin
            @(posedge CLK);
            #1;
            if (done || busy) seen++;
        end
        chk(tag, 32'(seen), 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nRST = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        rv32b_control = '{claim: 1'b0, op: OP_SH1ADD};
        #23;
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst done", {31'h0, done}, 32'h0);
        chk("rst result", result, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // SH2ADD also checks busy drops after one cycle via run_op
        run_op("sh2add", OP_SH2ADD, 32'h00000003, 32'h00000005,
               32'h00000011, 1);
        run_op("sh3add", OP_SH3ADD, 32'h20000001, 32'h00000010,
               32'h00000018, 1);
        run_op("andn", OP_ANDN, 32'hFF00FF00, 32'h0F0F0F0F,
               32'hF000F000, 1);
        run_op("rol", OP_ROL, 32'h80000001, 32'h00000021,
               32'h00000003, 1);
        run_op("ror", OP_ROR, 32'h00000001, 32'hFFFFFFE1,
               32'h80000000, 1);
        run_op("bext", OP_BEXT, 32'h00000100, 32'h00000028,
               32'h00000001, 1);
        run_op("bset", OP_BSET, 32'h00000000, 32'hFFFFFFFF,
               32'h80000000, 1);
        run_op("min", OP_MIN, 32'hFFFFFFFF, 32'h00000001,
               32'hFFFFFFFF, 1);
        run_op("max", OP_MAX, 32'hFFFFFFFF, 32'h00000001,
               32'h00000001, 1);
        run_op("minu", OP_MINU, 32'hFFFFFFFF, 32'h00000001,
               32'h00000001, 1);
        run_op("sextb", OP_SEXTB, 32'h00000080, 32'h0,
               32'hFFFFFF80, 1);
        run_op("orc", OP_ORC, 32'h00120300, 32'h0,
               32'h00FFFF00, 1);
        run_op("rev8", OP_REV8, 32'h11223344, 32'h0,
               32'h44332211, 1);
        run_op("clz", OP_CLZ, 32'h00010000, 32'h0, 32'd15, 9);
        run_op("clz0", OP_CLZ, 32'h00000000, 32'h0, 32'd32, 9);
        run_op("cpop", OP_CPOP, 32'hF0F0F0F1, 32'h0, 32'd17, 9);
        run_op("ctz", OP_CTZ, 32'h80000000, 32'h0, 32'd31, 9);
        run_op("ctz0", OP_CTZ, 32'h00000000, 32'h0, 32'd32, 9);

        // flush during the fourth cycle of a CPOP; result stays 32
        @(negedge CLK);
        rv32b_control = '{claim: 1'b1, op: OP_CPOP};
        rs1_data = 32'hFFFFFFFF;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        chk("flush busy", {30'h0, busy, done}, 32'h0);
        chk("flush result", result, 32'd32);
        watch_no_done("flush quiet", 12);

        @(negedge CLK);
        rv32b_control = '{claim: 1'b1, op: OP_SH1ADD};
        rs1_data = 32'h1;
        rs2_data = 32'h1;
        start = 1'b1;
        flush = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("start+flush", {30'h0, busy, done}, 32'h0);
        watch_no_done("start+flush quiet", 4);
        chk("start+flush res", result, 32'd32);

        @(negedge CLK);
        rv32b_control = '{claim: 1'b0, op: OP_SH1ADD};
        start = 1'b1;
        watch_no_done("noclaim", 6);
        start = 1'b0;
        chk("noclaim res", result, 32'd32);

        // async reset in the middle of a CLZ
        @(negedge CLK);
        rv32b_control = '{claim: 1'b1, op: OP_CLZ};
        rs1_data = 32'h00000001;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk("amid rst", {30'h0, busy, done}, 32'h0);
        chk("amid rst res", result, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        watch_no_done("post rst quiet", 12);

        run_op("after rst", OP_XNOR, 32'h0F0F0F0F, 32'h00FF00FF,
               32'hF00FF00F, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
